// File: rtl/demux1_4_reg.sv
// rtl/demux1_4_reg.sv - registered 1-to-4 demultiplexer with per-channel transfer counters
//
// Routes each accepted input word into the single-entry holding register of
// the channel chosen by in_sel. Every channel drains on its own handshake and
// counts the words it has accepted.
//
// Ports:
//   clk        - rising-edge clock
//   reset_n    - asynchronous active-low reset
//   in_valid   - producer presents a word
//   in_sel     - destination channel 0..3
//   in_data    - word to route
//   in_ready   - selected channel can take the word this cycle
//   out_valid  - bit k: channel k holds a word
//   out_data   - channel k word on [k*WIDTH +: WIDTH]
//   out_ready  - bit k: channel k consumer takes its word this cycle
//   xfer_cnt   - channel k accepted-word count on [k*CNTW +: CNTW]

module demux1_4_reg #(
    parameter int WIDTH = 64,
    parameter int CNTW  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic [1:0]           in_sel,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic [3:0]           out_valid,
    output logic [4*WIDTH-1:0]   out_data,
    input  logic [3:0]           out_ready,
    output logic [4*CNTW-1:0]    xfer_cnt
);

    logic [3:0]       v;
    logic [WIDTH-1:0] d   [4];
    logic [CNTW-1:0]  cnt [4];
    logic             in_hs;

    // A channel can accept when empty, or when its current word leaves on the
    // same edge; this gives one word per cycle per channel.
    assign in_ready = ~v[in_sel] | out_ready[in_sel];
    assign in_hs    = in_valid & in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v <= '0;
            for (int k = 0; k < 4; k++) begin
                d[k]   <= '0;
                cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (in_hs && (in_sel == 2'(k))) begin
                    // Load wins over drain: a simultaneous consume keeps v set.
                    d[k]   <= in_data;
                    v[k]   <= 1'b1;
                    cnt[k] <= cnt[k] + CNTW'(1);
                end else if (out_ready[k]) begin
                    // Clearing an already-empty channel is harmless; d is held.
                    v[k] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = v;

    for (genvar k = 0; k < 4; k++) begin : g_out
        assign out_data[k*WIDTH +: WIDTH] = d[k];
        assign xfer_cnt[k*CNTW +: CNTW]   = cnt[k];
    end

endmodule

// File: tb/tb_demux1_4_reg.sv
// tb/tb_demux1_4_reg.sv - scoreboard testbench for demux1_4_reg

module tb_demux1_4_reg;

    localparam int WIDTH = 64;
    localparam int CNTW  = 16;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               in_valid;
    logic [1:0]         in_sel;
    logic [WIDTH-1:0]   in_data;
    logic               in_ready;
    logic [3:0]         out_valid;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_ready;
    logic [4*CNTW-1:0]  xfer_cnt;

    demux1_4_reg #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model and per-channel scoreboard queues.
    logic [3:0]       mv;
    logic [WIDTH-1:0] md   [4];
    logic [CNTW-1:0]  mcnt [4];
    logic [WIDTH-1:0] exp_q [4][$];

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [4*WIDTH-1:0] model_data();
        logic [4*WIDTH-1:0] r;
        for (int k = 0; k < 4; k++) r[k*WIDTH +: WIDTH] = md[k];
        return r;
    endfunction

    function automatic logic [4*CNTW-1:0] model_cnt();
        logic [4*CNTW-1:0] r;
        for (int k = 0; k < 4; k++) r[k*CNTW +: CNTW] = mcnt[k];
        return r;
    endfunction

    task automatic model_clear();
        mv = '0;
        for (int k = 0; k < 4; k++) begin
            md[k]   = '0;
            mcnt[k] = '0;
            exp_q[k].delete();
        end
    endtask

    // Called on a falling edge: drives one cycle, scores it, returns on the next falling edge.
    task automatic step(input logic vld, input logic [1:0] sel, input logic [WIDTH-1:0] dat,
                        input logic [3:0] ordy);
        logic mrdy;
        in_valid  = vld;
        in_sel    = sel;
        in_data   = dat;
        out_ready = ordy;
        #1;
        mrdy = ~mv[sel] | ordy[sel];
        chk("in_ready", 256'(in_ready), 256'(mrdy));
        for (int k = 0; k < 4; k++) begin
            if (mv[k] && ordy[k]) begin
                if (exp_q[k].size() == 0) begin
                    chk("pop_empty", 256'(1), 256'(0));
                end else begin
                    chk($sformatf("pop_ch%0d", k), 256'(out_data[k*WIDTH +: WIDTH]),
                        256'(exp_q[k].pop_front()));
                end
            end
        end
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (vld && mrdy && sel == 2'(k)) begin
                mv[k]   = 1'b1;
                md[k]   = dat;
                mcnt[k] = mcnt[k] + 16'd1;
                exp_q[k].push_back(dat);
            end else if (ordy[k]) begin
                mv[k] = 1'b0;
            end
        end
        @(negedge clk);
        chk("out_valid", 256'(out_valid), 256'(mv));
        chk("out_data", 256'(out_data), 256'(model_data()));
        chk("xfer_cnt", 256'(xfer_cnt), 256'(model_cnt()));
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = '0;
        out_ready = 4'b0000;
        #2;
        model_clear();
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_out_data", 256'(out_data), 256'(0));
        chk("rst_xfer_cnt", 256'(xfer_cnt), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = '0;
        out_ready = 4'b0000;
        @(negedge clk);
        do_reset();

        // Single word to channel 2, held.
        step(1'b1, 2'd2, 64'hA5, 4'b0000);
        chk("t31_valid", 256'(out_valid), 256'(4'b0100));
        chk("t31_data", 256'(out_data[2*WIDTH +: WIDTH]), 256'(64'hA5));
        chk("t31_cnt", 256'(xfer_cnt[2*CNTW +: CNTW]), 256'(16'd1));
        in_valid = 1'b0; in_sel = 2'd2; #1;
        chk("t31_rdy_sel2", 256'(in_ready), 256'(0));
        in_sel = 2'd0; #1;
        chk("t31_rdy_sel0", 256'(in_ready), 256'(1));
        @(negedge clk);

        // Full channel 1 with simultaneous drain and load.
        step(1'b1, 2'd1, 64'h11, 4'b0000);
        step(1'b1, 2'd1, 64'h3C, 4'b0010);
        chk("t32_valid1", 256'(out_valid[1]), 256'(1));
        chk("t32_data1", 256'(out_data[1*WIDTH +: WIDTH]), 256'(64'h3C));
        chk("t32_cnt1", 256'(xfer_cnt[1*CNTW +: CNTW]), 256'(16'd2));

        // Stall on full channel 0, then release.
        step(1'b1, 2'd0, 64'h77, 4'b0000);
        for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 64'h88, 4'b0000);
        chk("t33_hold", 256'(out_data[0 +: WIDTH]), 256'(64'h77));
        chk("t33_cnt", 256'(xfer_cnt[0 +: CNTW]), 256'(16'd1));
        step(1'b1, 2'd0, 64'h88, 4'b0001);
        chk("t33_accept", 256'(out_data[0 +: WIDTH]), 256'(64'h88));

        // Drain everything, then four back-to-back words.
        step(1'b0, 2'd0, 64'h0, 4'b1111);
        for (int k = 0; k < 4; k++) step(1'b1, 2'(k), 64'(k + 1), 4'b0000);
        chk("t34_full", 256'(out_valid), 256'(4'b1111));
        step(1'b0, 2'd0, 64'h0, 4'b1111);
        chk("t34_empty", 256'(out_valid), 256'(4'b0000));

        // Random traffic.
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 {$urandom, $urandom}, 4'($urandom_range(0, 15)));

        // Asynchronous reset between edges while channels are full.
        for (int k = 0; k < 4; k++) step(1'b1, 2'(k), 64'hF0 + 64'(k), 4'b0000);
        #2;
        reset_n = 1'b0;
        #1;
        model_clear();
        chk("t36_valid", 256'(out_valid), 256'(0));
        chk("t36_cnt", 256'(xfer_cnt), 256'(0));
        chk("t36_rdy", 256'(in_ready), 256'(1));
        @(posedge clk);
        #1;
        chk("t36_hold_rst", 256'(out_valid), 256'(0));
        reset_n = 1'b1;
        @(negedge clk);
        step(1'b1, 2'd3, 64'h55, 4'b0000);
        chk("t30_first", 256'(xfer_cnt[3*CNTW +: CNTW]), 256'(16'd1));

        // Counter wrap on channel 3.
        do_reset();
        for (int i = 0; i < 65535; i++) step(1'b1, 2'd3, 64'(i), 4'b1000);
        chk("t35_max", 256'(xfer_cnt[3*CNTW +: CNTW]), 256'(16'hFFFF));
        step(1'b1, 2'd3, 64'hDEAD, 4'b1000);
        chk("t35_wrap", 256'(xfer_cnt[3*CNTW +: CNTW]), 256'(16'h0000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux1_4_reg.md
DEMUX1_4_REG -- requirements
Module: demux1_4_reg

Interface
REQ-001 Parameter WIDTH, default 64, is the data width of every channel in bits.
REQ-002 Parameter CNTW, default 16, is the width of each per-channel transfer counter.
REQ-003 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  is the asynchronous, active-low reset.
REQ-005 in_valid  input  1  means the upstream producer presents a word.
REQ-006 in_sel  input  2  selects the destination channel, 0..3.
REQ-007 in_data  input  WIDTH  is the word to route.
REQ-008 in_ready  output  1  means the block accepts the presented word this cycle.
REQ-009 out_valid  output  4  bit k means channel k holds a word.
REQ-010 out_data  output  4*WIDTH  holds channel k's word on bits [k*WIDTH +: WIDTH].
REQ-011 out_ready  input  4  bit k means the channel k consumer takes its word this cycle.
REQ-012 xfer_cnt  output  4*CNTW  holds channel k's accepted-word count on bits [k*CNTW +: CNTW].

Function
REQ-013 Each channel k SHALL contain one holding register: a valid bit v[k] and a data register d[k].
- out_valid[k] = v[k].
- out_data slice k = d[k].
REQ-014 An input handshake SHALL occur when in_valid & in_ready are both high at a rising clk edge.
REQ-015 An output handshake on channel k SHALL occur when v[k] & out_ready[k] are both high at a rising clk edge.
REQ-016 in_ready SHALL be combinational and equal to (~v[in_sel] | out_ready[in_sel]).
- It does not depend on in_valid.
- It is independent of the state of non-selected channels.
REQ-017 On an input handshake, the word SHALL be written to d[in_sel] and v[in_sel] set to 1 at that edge.
- Latency is 1 cycle: the word is visible on out_data the cycle after acceptance.
REQ-018 Simultaneous input handshake and output handshake on the same channel SHALL do both:
- the old word is consumed;
- the new word is loaded;
- v[k] stays 1, giving full throughput of 1 word/cycle per channel.
REQ-019 An output handshake on channel k with no input handshake to k SHALL clear v[k]; d[k] is held.
REQ-020 Channels other than in_sel SHALL be unaffected by an input handshake.
- Each channel drains independently and concurrently.
REQ-021 in_valid high with in_ready low SHALL leave all state unchanged (stall).
- The producer must hold in_sel and in_data until accepted.
REQ-022 d[k] SHALL not change while v[k]=1 unless REQ-018 applies.
REQ-023 xfer_cnt slice k SHALL increment by 1 on each input handshake to channel k.
REQ-024 Each counter SHALL wrap from 2^CNTW-1 to 0 with no saturation and no flag.
REQ-025 out_ready[k] asserted while v[k]=0 SHALL have no effect.
REQ-026 in_sel values SHALL be treated as unsigned 2-bit; all four are legal; no error path exists.

Reset
REQ-027 While reset_n=0, asynchronously:
- v[3:0]=0, so out_valid=4'b0000;
- d[k]=0 for all k, so out_data=0;
- all xfer_cnt slices=0.
REQ-028 in_ready SHALL read 1 during reset, since all channels are empty.
- No handshake is recorded until reset_n has risen.
REQ-029 Reset asserted mid-operation SHALL discard all held words and counts immediately, without waiting for clk.
REQ-030 The first input handshake SHALL be possible at the first rising clk edge after reset_n deasserts.

Verification
REQ-031 Reset, then in_sel=2, in_data=0xA5, in_valid=1 for one cycle, out_ready=0
-> next cycle: out_valid=4'b0100, channel 2 data=0xA5, xfer_cnt[2]=1, in_ready=0 for sel=2, in_ready=1 for sel=0.
REQ-032 Channel 1 full and out_ready[1]=1, with new word 0x3C to sel=1 in the same cycle
-> v[1] stays 1, channel 1 data=0x3C, xfer_cnt[1] increments by 1.
REQ-033 Channel 0 full, out_ready=0, in_sel=0, in_valid=1 for 3 cycles
-> in_ready=0 throughout, no state or counter change; raising out_ready[0] accepts the word next edge.
REQ-034 Four back-to-back words 0x1..0x4 to sel=0..3 with out_ready=0
-> out_valid=4'b1111, each channel holds its word; then out_ready=4'b1111 for one cycle -> out_valid=4'b0000.
REQ-035 Preload xfer_cnt[3] to 0xFFFF via 65535 transfers, then one more transfer -> xfer_cnt[3]=0x0000.
REQ-036 reset_n pulsed low between clk edges while channels are full
-> out_valid=0 and counters=0 before the next edge; in_ready=1.
